// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the 8259A interrupt acknowledge sequencer.
package interrupt_ack_sequencer_pkg;

  localparam int unsigned LEVEL_W = 8;
  localparam int unsigned LVL_W   = 3;

  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL_DEFAULT = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_ACK1  = 3'd2;
  localparam logic [2:0] ST_WAIT2 = 3'd3;
  localparam logic [2:0] ST_ACK2  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    ACK1  = ST_ACK1,
    WAIT2 = ST_WAIT2,
    ACK2  = ST_ACK2
  } state_t;

  function automatic logic [LEVEL_W-1:0] level_onehot(input logic [LVL_W-1:0] level);
    return LEVEL_W'(1) << level;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Fixed-priority encoder: bit 0 is highest priority.
module interrupt_ack_sequencer_priority_resolver
  import interrupt_ack_sequencer_pkg::*;
(
  input  logic [LEVEL_W-1:0] vec,
  output logic [LVL_W-1:0]   level,
  output logic               valid
);

  // Scan from lowest priority up so the highest-priority set bit is written last.
  always_comb begin
    level = '0;
    valid = 1'b0;
    for (int i = LEVEL_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        level = LVL_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Responder side of the 8259A request path: masking, priority, INT, 8086 INTA
// handshake, In-Service Register and EOI handling.
module interrupt_ack_sequencer
  import interrupt_ack_sequencer_pkg::*;
#(
  parameter logic [LVL_W-1:0] SPURIOUS_LEVEL = SPURIOUS_LEVEL_DEFAULT
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [LEVEL_W-1:0] Interrupt_Request_Reg,
  input  logic [LEVEL_W-1:0] Interrupt_Mask_Reg,
  input  logic [4:0]         Vector_Base,
  input  logic               Auto_EOI,
  input  logic               INTA_n,
  input  logic               EOI_Cmd,
  input  logic               Specific_EOI_Cmd,
  input  logic [LVL_W-1:0]   EOI_Level,
  output logic               INT,
  output logic [LEVEL_W-1:0] Clear_IRR,
  output logic [LEVEL_W-1:0] In_Service_Reg,
  output logic [LEVEL_W-1:0] Data_Out,
  output logic               Data_Out_En
);

  state_t             state, state_next;
  logic               inta_n_q;
  logic [LVL_W-1:0]   lat_level, lat_level_next;
  logic               lat_spur, lat_spur_next;
  logic               int_next, doe_next;
  logic [LEVEL_W-1:0] dout_next, set_mask, auto_clear, eoi_clear, isr_next;

  logic [LEVEL_W-1:0] pending;
  logic [LVL_W-1:0]   pend_level, isr_level;
  logic               pend_valid, isr_valid, valid_req;
  logic               inta_fall, inta_rise;

  assign pending   = Interrupt_Request_Reg & ~Interrupt_Mask_Reg;
  assign inta_fall = inta_n_q & ~INTA_n;
  assign inta_rise = ~inta_n_q & INTA_n;

  interrupt_ack_sequencer_priority_resolver u_pend_resolver (
    .vec   (pending),
    .level (pend_level),
    .valid (pend_valid)
  );

  interrupt_ack_sequencer_priority_resolver u_isr_resolver (
    .vec   (In_Service_Reg),
    .level (isr_level),
    .valid (isr_valid)
  );

  // A request nests only if strictly higher priority than everything in service.
  assign valid_req = pend_valid && (!isr_valid || (pend_level < isr_level));

  always_comb begin
    state_next     = state;
    int_next       = INT;
    doe_next       = Data_Out_En;
    dout_next      = Data_Out;
    lat_level_next = lat_level;
    lat_spur_next  = lat_spur;
    set_mask       = '0;
    auto_clear     = '0;
    case (state)
      IDLE: begin
        if (valid_req) begin
          state_next = REQ;
          int_next   = 1'b1;
        end
      end
      REQ: begin
        if (inta_fall) begin
          state_next = ACK1;
          int_next   = 1'b0;
          if (valid_req) begin
            lat_level_next = pend_level;
            lat_spur_next  = 1'b0;
            set_mask       = level_onehot(pend_level);
          end else begin
            lat_level_next = SPURIOUS_LEVEL;
            lat_spur_next  = 1'b1;
          end
        end else if (!valid_req) begin
          state_next = IDLE;
          int_next   = 1'b0;
        end
      end
      ACK1: begin
        if (inta_rise) state_next = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_next = ACK2;
          dout_next  = {Vector_Base, lat_level};
          doe_next   = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_next = IDLE;
          doe_next   = 1'b0;
          if (Auto_EOI && !lat_spur) auto_clear = level_onehot(lat_level);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Specific EOI takes precedence over a coincident non-specific EOI.
  always_comb begin
    eoi_clear = '0;
    if (Specific_EOI_Cmd)          eoi_clear = level_onehot(EOI_Level);
    else if (EOI_Cmd && isr_valid) eoi_clear = level_onehot(isr_level);
    isr_next = (In_Service_Reg & ~(eoi_clear | auto_clear)) | set_mask;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      inta_n_q       <= 1'b1;
      lat_level      <= '0;
      lat_spur       <= 1'b0;
      INT            <= 1'b0;
      Clear_IRR      <= '0;
      In_Service_Reg <= '0;
      Data_Out       <= '0;
      Data_Out_En    <= 1'b0;
    end else begin
      state          <= state_next;
      inta_n_q       <= INTA_n;
      lat_level      <= lat_level_next;
      lat_spur       <= lat_spur_next;
      INT            <= int_next;
      Clear_IRR      <= set_mask;
      In_Service_Reg <= isr_next;
      Data_Out       <= dout_next;
      Data_Out_En    <= doe_next;
    end
  end

endmodule
